// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Two-flop synchroniser followed by a stability counter for one raw,
//   asynchronous, bouncing input pin. The output level is normalised so that
//   1 means "active" (the opposite of RESET_LEVEL). It is reusable for any
//   push-button or slow GPIO line.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level (>=2)
//   RESET_LEVEL      raw pin level that means "released"; the synchroniser
//                    resets to it and the normalisation is taken relative to it
//
// Ports
//   clock    input   system clock, rising edge
//   reset    input   asynchronous, active-high; discards all filter progress
//   pin_i    input   raw asynchronous pin
//   level_o  output  debounced level, 1 = active
//   rise_o   output  registered one-cycle strobe on each accepted 0->1 of level_o
// -----------------------------------------------------------------------------
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             active;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Synchroniser resets to the released level so no phantom edge is seen
  // when reset is removed.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: the released level maps to 0.
  assign active = sync2_q ^ RESET_LEVEL;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreeing sample restarts it, so it can never exceed
  // CNT_LAST and needs no saturation.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (active == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = active;
      rise_d  = active;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/reset_button_conditioner.sv
// -----------------------------------------------------------------------------
// reset_button_conditioner
//   Board-level front end producing the SoC's active-low reset. A raw push
//   button is synchronised and debounced; every reset (power-up, PLL unlock,
//   button press) is stretched to at least MIN_RESET_CYCLES, and the SoC is
//   held in reset for as long as the button stays pressed.
//
// Parameters
//   DEBOUNCE_CYCLES     stable cycles needed to accept a new button level (>=2)
//   MIN_RESET_CYCLES    minimum soc_reset_n low width in clock cycles (>=2)
//   BUTTON_ACTIVE_HIGH  1: pressed = button_in high; 0: pressed = button_in low
//
// Ports
//   clock               input   system clock, rising edge
//   reset               input   asynchronous, active-high; forces the reset state
//   button_in           input   raw, asynchronous, bouncing push-button pin
//   soc_reset_n         output  registered active-low SoC reset (single flop)
//   button_debounced    output  debounced button level, 1 = pressed
//   button_press_pulse  output  one-cycle strobe on each accepted press that
//                               starts a new reset
// -----------------------------------------------------------------------------
module reset_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 120000,
  parameter int unsigned MIN_RESET_CYCLES   = 1024,
  parameter bit          BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic soc_reset_n,
  output logic button_debounced,
  output logic button_press_pulse
);

  localparam logic [1:0] ST_HOLD         = 2'd0;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN          = 2'd2;

  typedef enum logic [1:0] {
    HOLD         = ST_HOLD,
    WAIT_RELEASE = ST_WAIT_RELEASE,
    RUN          = ST_RUN
  } state_e;

  localparam int unsigned       HOLD_W    = (MIN_RESET_CYCLES > 1) ? $clog2(MIN_RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RESET_CYCLES - 1);

  logic               deb_level;
  logic               deb_rise;
  state_e             state_q,      state_d;
  logic [HOLD_W-1:0]  hold_cnt_q,   hold_cnt_d;
  logic               soc_rst_n_q,  soc_rst_n_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (!BUTTON_ACTIVE_HIGH)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .pin_i   (button_in),
    .level_o (deb_level),
    .rise_o  (deb_rise)
  );

  // soc_reset_n is computed one edge ahead so the output itself is a flop
  // and cannot glitch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    soc_rst_n_d = soc_rst_n_q;
    unique case (state_q)
      HOLD: begin
        soc_rst_n_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (deb_level) begin
            state_d = WAIT_RELEASE;
          end else begin
            state_d     = RUN;
            soc_rst_n_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      WAIT_RELEASE: begin
        soc_rst_n_d = 1'b0;
        if (!deb_level) begin
          state_d     = RUN;
          soc_rst_n_d = 1'b1;
        end
      end
      RUN: begin
        soc_rst_n_d = 1'b1;
        if (deb_rise) begin
          state_d     = HOLD;
          soc_rst_n_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end
      default: begin
        state_d     = HOLD;
        soc_rst_n_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      soc_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_rst_n_q <= soc_rst_n_d;
    end
  end

  assign soc_reset_n      = soc_rst_n_q;
  assign button_debounced = deb_level;
  // Presses that land while the SoC is already held in reset (stretch or
  // button held through power-up) start nothing, so they are not reported.
  assign button_press_pulse = deb_rise && (state_q == RUN);

endmodule

// File: tb/tb_reset_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_reset_button_conditioner
//   Directed bench with DEBOUNCE_CYCLES=4, MIN_RESET_CYCLES=8. dut_h uses an
//   active-high button, dut_l an active-low one held pressed through reset.
//   Inputs change 1 time unit after a rising edge; "edge N" is the Nth rising
//   edge after the change, and outputs are sampled 1 unit after that edge.
// -----------------------------------------------------------------------------
module tb_reset_button_conditioner;

  logic clock  = 1'b0;
  logic clk_en = 1'b1;

  logic rst_h, rst_l, pin_h, pin_l;
  logic soc_h, deb_h, pls_h;
  logic soc_l, deb_l, pls_l;

  int n_checks = 0;
  int n_pass   = 0;

  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES    (4),
    .MIN_RESET_CYCLES   (8),
    .BUTTON_ACTIVE_HIGH (1'b1)
  ) dut_h (
    .clock              (clock),
    .reset              (rst_h),
    .button_in          (pin_h),
    .soc_reset_n        (soc_h),
    .button_debounced   (deb_h),
    .button_press_pulse (pls_h)
  );

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES    (4),
    .MIN_RESET_CYCLES   (8),
    .BUTTON_ACTIVE_HIGH (1'b0)
  ) dut_l (
    .clock              (clock),
    .reset              (rst_l),
    .button_in          (pin_l),
    .soc_reset_n        (soc_l),
    .button_debounced   (deb_l),
    .button_press_pulse (pls_l)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_h = 1'b1;
    rst_l = 1'b1;
    pin_h = 1'b0;
    pin_l = 1'b0;  // active-low button pressed through reset

    // Reset state
    repeat (3) step();
    check("rst soc_h", soc_h, 1'b0);
    check("rst deb_h", deb_h, 1'b0);
    check("rst pls_h", pls_h, 1'b0);
    check("rst soc_l", soc_l, 1'b0);
    check("rst deb_l", deb_l, 1'b0);
    check("rst pls_l", pls_l, 1'b0);

    // 1: release reset, button idle -> rises on edge 8
    rst_h = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step();
      check($sformatf("t1 soc e%0d", e), soc_h, (e >= 8));
      check($sformatf("t1 pls e%0d", e), pls_h, 1'b0);
    end

    // 2: 3-cycle bursts with 1-cycle gaps never get accepted
    for (int k = 0; k < 3; k++) begin
      pin_h = 1'b1;
      repeat (3) begin
        step();
        check($sformatf("t2 deb burst%0d", k), deb_h, 1'b0);
      end
      pin_h = 1'b0;
      step();
      check($sformatf("t2 soc gap%0d", k), soc_h, 1'b1);
    end
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("t2 deb idle%0d", e), deb_h, 1'b0);
      check($sformatf("t2 soc idle%0d", e), soc_h, 1'b1);
    end

    // 3: 6-cycle press -> debounced edge 6, reset low edges 7..14, high edge 15
    pin_h = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("t3 deb e%0d", e), deb_h, (e >= 6));
      check($sformatf("t3 pls e%0d", e), pls_h, (e == 6));
      check($sformatf("t3 soc e%0d", e), soc_h, 1'b1);
    end
    pin_h = 1'b0;
    for (int e = 7; e <= 16; e++) begin
      step();
      check($sformatf("t3 soc e%0d", e), soc_h, (e >= 15));
      check($sformatf("t3 deb e%0d", e), deb_h, (e < 12));
      check($sformatf("t3 pls e%0d", e), pls_h, 1'b0);
    end

    // 4: 40-cycle press -> held low until the debounced release
    pin_h = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      check($sformatf("t4 deb e%0d", e), deb_h, (e >= 6));
      check($sformatf("t4 soc e%0d", e), soc_h, (e <= 6));
      check($sformatf("t4 pls e%0d", e), pls_h, (e == 6));
    end
    pin_h = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      step();
      check($sformatf("t4 deb r%0d", r), deb_h, (r < 6));
      if (r != 6) check($sformatf("t4 soc r%0d", r), soc_h, (r > 6));
    end

    // 5: async reset mid-debounce with the clock stopped
    pin_h = 1'b1;
    repeat (3) step();
    check("t5 soc before", soc_h, 1'b1);
    @(negedge clock);
    clk_en = 1'b0;
    #3;
    rst_h = 1'b1;
    #1;
    check("t5 soc async", soc_h, 1'b0);
    check("t5 deb async", deb_h, 1'b0);
    #10;
    pin_h = 1'b0;
    rst_h = 1'b0;
    #10;
    clk_en = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("t5 soc e%0d", e), soc_h, (e >= 8));
      check($sformatf("t5 deb e%0d", e), deb_h, 1'b0);
    end

    // 6: active-low button held through reset -> WAIT_RELEASE, no pulse
    rst_l = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("t6 deb e%0d", e), deb_l, (e >= 6));
      check($sformatf("t6 pls e%0d", e), pls_l, 1'b0);
      check($sformatf("t6 soc e%0d", e), soc_l, 1'b0);
    end
    pin_l = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      check($sformatf("t6 deb r%0d", r), deb_l, (r < 6));
      check($sformatf("t6 pls r%0d", r), pls_l, 1'b0);
      if (r != 6) check($sformatf("t6 soc r%0d", r), soc_l, (r > 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
